// File: rtl/mux_rr_param_pkg.sv
// Shared constants for the round-robin / fixed-select channel mux.
// The mode encodings here are used by the RTL and by the testbench.
package mux_rr_param_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Index width for n channels, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_rr_param_rr_arb.sv
// Rotating-priority search: finds the first set request at or after ptr,
// wrapping modulo NUM_CH.
module rr_arb
    import mux_rr_param_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              gnt_valid,
    output logic [SEL_W-1:0]  idx
);

    // NOTE: every output gets a default before the loop, so no path leaves
    // them unassigned and no latch is inferred.
    always_comb begin
        gnt_valid = 1'b0;
        idx       = '0;
        // Scan farthest-first so the request closest to ptr is the last write.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (req[j]) begin
                gnt_valid = 1'b1;
                idx       = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/mux_rr_param.sv
// Channel mux with fixed or round-robin selection feeding a single registered
// output stage with valid/ready flow control.
module mux_rr_param
    import mux_rr_param_pkg::*;
#(
    parameter  int WIDTH  = 2,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        selector,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]       valid_in,
    input  logic                    ready_in,
    output logic [NUM_CH-1:0]       pop_out,
    output logic [WIDTH-1:0]        data_out,
    output logic                    valid_out,
    output logic [SEL_W-1:0]        sel_out
);

    logic                  load;
    logic                  grant;
    logic                  arb_valid;
    logic                  cand_valid;
    logic [SEL_W-1:0]      arb_idx;
    logic [SEL_W-1:0]      cand;
    logic [SEL_W-1:0]      ptr;
    logic [SEL_W-1:0]      ptr_next;
    logic [WIDTH-1:0]      data_next;
    logic [2**SEL_W-1:0]   valid_pad;

    rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .req       (valid_in),
        .ptr       (ptr),
        .gnt_valid (arb_valid),
        .idx       (arb_idx)
    );

    // Padding valid_in to the full selector range makes out-of-range
    // selector values read as "not valid", so they can never grant.
    always_comb begin
        valid_pad               = '0;
        valid_pad[NUM_CH-1:0]   = valid_in;
        if (mode == MODE_RR) begin
            cand       = arb_idx;
            cand_valid = arb_valid;
        end else begin
            cand       = selector;
            cand_valid = valid_pad[selector];
        end
    end

    assign load  = !valid_out || ready_in;
    assign grant = reset_L && load && cand_valid;

    always_comb begin
        pop_out   = '0;
        data_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant && cand == SEL_W'(i)) begin
                pop_out[i] = 1'b1;
                data_next  = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (cand == SEL_W'(NUM_CH - 1)) ? '0 : cand + SEL_W'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            sel_out   <= '0;
            ptr       <= '0;
        end else begin
            if (load) begin
                valid_out <= grant;
                data_out  <= data_next;
                sel_out   <= grant ? cand : '0;
            end
            if (grant) ptr <= ptr_next;
        end
    end

endmodule
